div_pow2_arbiter: RTL and testbench

//  Shares one power-of-two divider (Q3_Div: Q = M>>N, R = M mod 2^N) among NREQ requesters.

---
 rtl/div_pow2_pkg.sv | 7 +
 rtl/div_pow2_arbiter_rr_arbiter.sv | 25 ++
 rtl/q3_div.sv | 13 +
 rtl/div_pow2_arbiter.sv | 99 +++++++++
 tb/tb_div_pow2_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pow2_pkg.sv
// Shared widths and FSM encoding for the power-of-two divider arbiter.
package div_pow2_pkg;
    localparam int DW = 16;
    localparam int SW = 4;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} div_arb_state_t;
endpackage

// File: rtl/div_pow2_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (en && !any && req[(int'(ptr) + k) % NREQ]) begin
                grant[(int'(ptr) + k) % NREQ] = 1'b1;
                idx = ID_W'((int'(ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/q3_div.sv
// Combinational power-of-two divider: q = m >> n, r = m mod 2^n.
module Q3_Div
    import div_pow2_pkg::*;
(
    input  logic [DW-1:0] m,
    input  logic [SW-1:0] n,
    output logic [DW-1:0] q,
    output logic [DW-1:0] r
);
    assign q = m >> n;
    // Keep only the bits shifted out; the mask never reaches bit 15 since n <= 15.
    assign r = m & ~({DW{1'b1}} << n);
endmodule

// File: rtl/div_pow2_arbiter.sv
// Time-shares one Q3_Div among NREQ requesters with round-robin grants
// and a single tagged valid/ready response channel.
module div_pow2_arbiter
    import div_pow2_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*16-1:0] req_m,
    input  logic [NREQ*4-1:0]  req_n,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [15:0]        rsp_q,
    output logic [15:0]        rsp_r,
    output logic               busy
);
    div_arb_state_t state, state_nx;

    logic [ID_W-1:0] rr_ptr;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic [DW-1:0]   op_m_p0;
    logic [SW-1:0]   op_n_p0;
    logic [ID_W-1:0] op_id_p0;
    logic [DW-1:0]   div_q;
    logic [DW-1:0]   div_r;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (state == IDLE),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign req_ready = grant;

    Q3_Div u_div (
        .m (op_m_p0),
        .n (op_n_p0),
        .q (div_q),
        .r (div_r)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_any) state_nx = EXEC;
            EXEC:    state_nx = HOLD;
            HOLD:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_m_p0   <= '0;
            op_n_p0   <= '0;
            op_id_p0  <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            case (state)
                // p0: operands of the granted requester
                IDLE: if (grant_any) begin
                    op_m_p0  <= req_m[DW*int'(grant_idx) +: DW];
                    op_n_p0  <= req_n[SW*int'(grant_idx) +: SW];
                    op_id_p0 <= grant_idx;
                end
                // p1: divider result into the response registers
                EXEC: begin
                    rsp_q     <= div_q;
                    rsp_r     <= div_r;
                    rsp_id    <= op_id_p0;
                    rsp_valid <= 1'b1;
                end
                HOLD: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rr_ptr    <= (op_id_p0 == ID_W'(NREQ - 1)) ? '0 : op_id_p0 + ID_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_pow2_arbiter.sv
// Directed bench for div_pow2_arbiter with an expected-response scoreboard.
module tb_div_pow2_arbiter;
    localparam int NREQ = 2;
    localparam int ID_W = $clog2(NREQ);

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_m;
    logic [NREQ*4-1:0]  req_n;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [15:0]        rsp_q;
    logic [15:0]        rsp_r;
    logic               busy;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] q;
        logic [15:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    div_pow2_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_m     (req_m),
        .req_n     (req_n),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference via integer division, independent of shift/mask formulation.
    task automatic push_exp(input int id, input logic [15:0] m, input logic [3:0] n);
        exp_t e;
        int   d;
        d    = 1 << n;
        e.id = 8'(id);
        e.q  = 16'(int'(m) / d);
        e.r  = 16'(int'(m) % d);
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_rsp"}, 32'(rsp_valid), 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_id"}, 32'(rsp_id), 32'(e.id));
            check({tag, "_q"},  32'(rsp_q),  32'(e.q));
            check({tag, "_r"},  32'(rsp_r),  32'(e.r));
        end
    endtask

    // Called at #1 after the accept edge; returns the number of edges until rsp_valid.
    task automatic wait_rsp(input string tag, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
        if (rsp_valid) pop_cmp(tag);
    endtask

    // Issue a single op at #1 into an IDLE cycle; leaves the bench at #1 of the next cycle.
    task automatic issue(input string tag, input int id, input logic [15:0] m, input logic [3:0] n);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        req_valid = oh;
        req_m[16*id +: 16] = m;
        req_n[4*id +: 4]   = n;
        #1;
        check({tag, "_req_ready"}, 32'(req_ready), 32'(oh));
        push_exp(id, m, n);
        step();
        req_valid = '0;
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_valid_clr"}, 32'(rsp_valid), 32'd0);
        check({tag, "_busy_clr"},  32'(busy),      32'd0);
    endtask

    initial begin
        int lat;
        int acc_cnt;
        int rsp_cnt;
        int last_acc;
        int cyc;
        int pend_id;
        int stray;
        logic [15:0] hq, hr;
        logic [ID_W-1:0] hid;

        rst = 1'b1;
        req_valid = '0;
        req_m = '0;
        req_n = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_q",     32'(rsp_q),     32'd0);
        check("reset_rsp_r",     32'(rsp_r),     32'd0);
        check("reset_rsp_id",    32'(rsp_id),    32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);

        // Basic op, latency and fixed arithmetic cases
        issue("t1", 0, 16'hABCD, 4'd4);
        check("t1_exec_busy",  32'(busy),      32'd1);
        check("t1_exec_valid", 32'(rsp_valid), 32'd0);
        wait_rsp("t1", lat);
        check("t1_latency", 32'(lat + 1), 32'd2);
        check("t1_q_const", 32'(rsp_q), 32'h0ABC);
        check("t1_r_const", 32'(rsp_r), 32'h000D);
        consume("t1");

        issue("t2a", 1, 16'h1234, 4'd0);
        wait_rsp("t2a", lat);
        check("t2a_q_const", 32'(rsp_q), 32'h1234);
        check("t2a_r_const", 32'(rsp_r), 32'h0000);
        consume("t2a");

        issue("t2b", 1, 16'hFFFF, 4'd15);
        wait_rsp("t2b", lat);
        check("t2b_q_const", 32'(rsp_q), 32'h0001);
        check("t2b_r_const", 32'(rsp_r), 32'h7FFF);
        consume("t2b");

        // Both requesters continuously valid: strict rotation, one accept per 3 cycles
        req_m = {16'h8421, 16'hF00F};
        req_n = {4'd3, 4'd7};
        req_valid = '1;
        rsp_ready = 1'b1;
        acc_cnt = 0;
        rsp_cnt = 0;
        last_acc = 0;
        pend_id = -1;
        cyc = 0;
        #1;
        while (rsp_cnt < 6 && cyc < 60) begin
            if (req_ready != '0) begin
                check("t3_grant_id", 32'(req_ready), 32'(1 << (acc_cnt % 2)));
                if (acc_cnt > 0) check("t3_accept_gap", 32'(cyc - last_acc), 32'd3);
                push_exp(req_ready[1] ? 1 : 0, req_ready[1] ? req_m[31:16] : req_m[15:0],
                         req_ready[1] ? req_n[7:4] : req_n[3:0]);
                last_acc = cyc;
                pend_id = req_ready[1] ? 1 : 0;
                acc_cnt++;
            end
            step();
            cyc++;
            if (pend_id >= 0) begin
                req_m[16*pend_id +: 16] = 16'($urandom);
                req_n[4*pend_id +: 4]   = 4'($urandom);
                pend_id = -1;
            end
            if (rsp_valid) begin
                pop_cmp("t3");
                rsp_cnt++;
                if (rsp_cnt == 6) req_valid = '0;
            end
        end
        check("t3_rsp_count", 32'(rsp_cnt), 32'd6);
        check("t3_acc_count", 32'(acc_cnt), 32'd6);
        step();
        rsp_ready = 1'b0;
        check("t3_idle_busy", 32'(busy), 32'd0);

        // Back-pressure in HOLD with both requesters asking
        issue("t4", 1, 16'h8001, 4'd3);
        wait_rsp("t4", lat);
        hq = rsp_q;
        hr = rsp_r;
        hid = rsp_id;
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold_valid", 32'(rsp_valid), 32'd1);
            check("t4_hold_q",     32'(rsp_q),     32'(hq));
            check("t4_hold_r",     32'(rsp_r),     32'(hr));
            check("t4_hold_id",    32'(rsp_id),    32'(hid));
            check("t4_hold_ready", 32'(req_ready), 32'd0);
            check("t4_hold_busy",  32'(busy),      32'd1);
        end
        req_valid = '0;
        consume("t4");

        // Reset during EXEC: op discarded, pointer back to 0
        issue("t5pre", 0, 16'h00F0, 4'd4);
        wait_rsp("t5pre", lat);
        consume("t5pre");
        req_valid = 2'b10;
        req_m[31:16] = 16'h5555;
        #1;
        check("t5_req_ready", 32'(req_ready), 32'b10);
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_busy",  32'(busy),      32'd0);
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid) stray++;
        end
        check("t5_no_rsp", 32'(stray), 32'd0);
        req_m[15:0] = 16'h7777;
        req_n[3:0] = 4'd1;
        req_valid = '1;
        #1;
        check("t5_grant_after_rst", 32'(req_ready), 32'b01);
        push_exp(0, req_m[15:0], req_n[3:0]);
        step();
        req_valid = '0;
        wait_rsp("t5", lat);
        consume("t5");

        // Requester 0 pulses valid only while HOLD: never accepted
        issue("t6", 1, 16'hC3A5, 4'd8);
        wait_rsp("t6", lat);
        req_valid = 2'b01;
        #1;
        check("t6_pulse_ready", 32'(req_ready), 32'd0);
        step();
        req_valid = '0;
        consume("t6");
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid || req_ready != '0) stray++;
            step();
        end
        check("t6_dropped_op", 32'(stray), 32'd0);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
